// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and state encoding for the channel scan sequencer.
//   SEL_W   : width of the channel select bus
//   N_CH    : number of selectable channels (2**SEL_W)
//   state_t : sequencer FSM states
package scan_pkg;

    localparam int SEL_W = 4;
    localparam int N_CH  = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/scan_next_ch.sv
// scan_next_ch: combinational search for the next enabled channel.
//   mask_i  [N_CH-1:0]  enabled channels
//   cur_i   [SEL_W-1:0] channel currently selected
//   next_o  [SEL_W-1:0] next enabled channel above cur_i, wrapping to the lowest
//   wrap_o              next_o did not advance past cur_i (wrapped or only channel)
//   first_o [SEL_W-1:0] lowest enabled channel of mask_i
// With an empty mask next_o/first_o are meaningless; callers never use them then.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask_i,
    input  logic [SEL_W-1:0] cur_i,
    output logic [SEL_W-1:0] next_o,
    output logic             wrap_o,
    output logic [SEL_W-1:0] first_o
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [SEL_W-1:0]  off;
    logic [SEL_W:0]    shamt;

    // Rotate the mask so bit 0 is the channel just above cur_i, then take the
    // lowest set bit of the rotated vector as the distance to the next channel.
    always_comb begin
        dbl   = {mask_i, mask_i};
        shamt = {1'b0, cur_i} + (SEL_W+1)'(1);
        rot   = dbl[shamt +: N_CH];
        off   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) off = SEL_W'(k);
        end
        next_o = cur_i + off + SEL_W'(1);
        wrap_o = (next_o <= cur_i);
    end

    always_comb begin
        first_o = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask_i[k]) first_o = SEL_W'(k);
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 4-bit channel select through a masked channel set,
// holding each channel for dwell+1 cycles, one pass or continuously.
//   clk_i, rst_i (async, active high)
//   start_i     one-cycle scan request (ignored while busy)
//   stop_i      one-cycle abort, wins over start
//   hold_i      freezes the dwell countdown while high
//   one_shot_i  1 = single pass, 0 = continuous (sampled at start)
//   dwell_i     dwell count (sampled at start)
//   ch_mask_i   enabled channels (sampled at start)
//   sel_o       current channel, drives the downstream 4-to-16 decoder
//   sel_valid_o sel_o is an active channel
//   step_o      pulse in the first cycle of each dwell period
//   busy_o      scan in progress
//   done_o      pulse when a scan ends (normal end or empty mask)
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start, sel_o holds last channel
// ST_RUN  | scanning, counting down the dwell per channel
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               hold_i,
    input  logic               one_shot_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [N_CH-1:0]    ch_mask_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic               sel_valid_o,
    output logic               step_o,
    output logic               busy_o,
    output logic               done_o
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic               one_shot_q, one_shot_d;
    logic               valid_q, valid_d;
    logic               step_q, step_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   next_ch;
    logic               next_wrap;
    logic [SEL_W-1:0]   unused_first;
    logic [SEL_W-1:0]   start_ch;
    logic               unused_start_wrap;
    logic [SEL_W-1:0]   unused_start_next;

    // Walks the latched mask during a scan.
    scan_next_ch u_next_run (
        .mask_i  (mask_q),
        .cur_i   (sel_q),
        .next_o  (next_ch),
        .wrap_o  (next_wrap),
        .first_o (unused_first)
    );

    // Finds the first channel of the mask presented with start.
    scan_next_ch u_next_start (
        .mask_i  (ch_mask_i),
        .cur_i   (sel_q),
        .next_o  (unused_start_next),
        .wrap_o  (unused_start_wrap),
        .first_o (start_ch)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            cnt_q      <= '0;
            dwell_q    <= '0;
            mask_q     <= '0;
            one_shot_q <= 1'b0;
            valid_q    <= 1'b0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
            mask_q     <= mask_d;
            one_shot_q <= one_shot_d;
            valid_q    <= valid_d;
            step_q     <= step_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        dwell_d    = dwell_q;
        mask_d     = mask_q;
        one_shot_d = one_shot_q;
        valid_d    = valid_q;
        step_d     = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    if (ch_mask_i != '0) begin
                        one_shot_d = one_shot_i;
                        dwell_d    = dwell_i;
                        mask_d     = ch_mask_i;
                        sel_d      = start_ch;
                        cnt_d      = dwell_i;
                        valid_d    = 1'b1;
                        step_d     = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (hold_i) begin
                    cnt_d = cnt_q;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (one_shot_q && next_wrap) begin
                    // Last channel of a single pass: sel_o keeps it visible.
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sel_d  = next_ch;
                    cnt_d  = dwell_q;
                    step_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_o       = sel_q;
        sel_valid_o = valid_q;
        step_o      = step_q;
        busy_o      = (state_q == ST_RUN);
        done_o      = done_q;
    end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;
    import scan_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, hold, one_shot;
    logic [DW-1:0] dwell;
    logic [15:0]   ch_mask;
    logic [3:0]    sel;
    logic          sel_valid, step, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .hold_i      (hold),
        .one_shot_i  (one_shot),
        .dwell_i     (dwell),
        .ch_mask_i   (ch_mask),
        .sel_o       (sel),
        .sel_valid_o (sel_valid),
        .step_o      (step),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct {
        logic        start, stop, hold, one_shot;
        logic [7:0]  dwell;
        logic [15:0] mask;
        logic [3:0]  e_sel;
        logic        e_valid, e_step, e_busy, e_done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic hd, input logic os,
                       input logic [7:0] dw, input logic [15:0] m,
                       input logic [3:0] s, input logic v, input logic sg,
                       input logic b, input logic d);
        vec_t r;
        r.start = st; r.stop = sp; r.hold = hd; r.one_shot = os;
        r.dwell = dw; r.mask = m;
        r.e_sel = s; r.e_valid = v; r.e_step = sg; r.e_busy = b; r.e_done = d;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs packed as {sel, sel_valid, step, busy, done}.
    function automatic logic [7:0] outs();
        return {sel, sel_valid, step, busy, done};
    endfunction

    task automatic drive(input logic st, input logic sp, input logic hd, input logic os,
                         input logic [7:0] dw, input logic [15:0] m);
        start = st; stop = sp; hold = hd; one_shot = os; dwell = dw; ch_mask = m;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'd0, 16'h0000);
        #12;
        chk("reset_state", 32'(outs()), 32'h00);
        rst = 1'b0;
        cyc();

        // Sparse continuous scan; mode/dwell/mask inputs change after start and must be ignored.
        add(1,0,0,0,8'd2,16'h8421,  4'd0, 1,1,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd0, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd0, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd5, 1,1,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd5, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd5, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd10,1,1,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd10,1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd10,1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd15,1,1,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd15,1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd15,1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd0, 1,1,1,0);
        add(1,0,0,1,8'd0,16'hFFFF,  4'd0, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd0, 1,0,1,0);
        add(0,0,0,1,8'd0,16'hFFFF,  4'd5, 1,1,1,0);
        add(0,1,0,0,8'd0,16'h8421,  4'd5, 0,0,0,0);
        add(0,0,0,0,8'd0,16'h8421,  4'd5, 0,0,0,0);
        // Full one-shot pass, dwell 0.
        add(1,0,0,1,8'd0,16'hFFFF,  4'd0, 1,1,1,0);
        for (int i = 1; i < 16; i++) add(0,0,0,0,8'd3,16'h0001, 4'(i), 1,1,1,0);
        add(0,0,0,0,8'd3,16'h0001,  4'd15,0,0,0,1);
        add(0,0,0,0,8'd3,16'h0001,  4'd15,0,0,0,0);
        // Empty mask.
        add(1,0,0,0,8'd3,16'h0000,  4'd15,0,0,0,1);
        add(0,0,0,0,8'd3,16'h0000,  4'd15,0,0,0,0);
        // start and stop together in IDLE.
        add(1,1,0,0,8'd0,16'hFFFF,  4'd15,0,0,0,0);
        add(0,0,0,0,8'd0,16'hFFFF,  4'd15,0,0,0,0);
        // Single channel, continuous: step still pulses every dwell+1 cycles.
        add(1,0,0,0,8'd1,16'h0010,  4'd4, 1,1,1,0);
        add(0,0,0,0,8'd1,16'h0010,  4'd4, 1,0,1,0);
        add(0,0,0,0,8'd1,16'h0010,  4'd4, 1,1,1,0);
        add(0,0,0,0,8'd1,16'h0010,  4'd4, 1,0,1,0);
        add(0,1,0,0,8'd1,16'h0010,  4'd4, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].one_shot,
                  vecs[i].dwell, vecs[i].mask);
            cyc();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].e_sel, vecs[i].e_valid, vecs[i].e_step,
                     vecs[i].e_busy, vecs[i].e_done}));
        end

        // Hold: channel 0 stretched from 2 to 5 cycles, channel 1 lasts 2.
        drive(1, 0, 0, 1, 8'd1, 16'h0003);
        cyc();
        chk("hold_c1", 32'(outs()), 32'({4'd0, 4'b1110}));
        drive(0, 0, 1, 1, 8'd1, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("hold_frozen%0d", i), 32'(outs()), 32'({4'd0, 4'b1010}));
        end
        hold = 1'b0;
        cyc();
        chk("hold_c5", 32'(outs()), 32'({4'd0, 4'b1010}));
        cyc();
        chk("hold_ch1_a", 32'(outs()), 32'({4'd1, 4'b1110}));
        cyc();
        chk("hold_ch1_b", 32'(outs()), 32'({4'd1, 4'b1010}));
        cyc();
        chk("hold_done", 32'(outs()), 32'({4'd1, 4'b0001}));

        // Async reset mid-run, checked between clock edges.
        drive(1, 0, 0, 0, 8'd5, 16'hFFFF);
        cyc();
        drive(0, 0, 0, 0, 8'd5, 16'hFFFF);
        cyc();
        cyc();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 32'(outs()), 32'h00);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("post_reset%0d", i), 32'(outs()), 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Generates the 4-bit channel select that drives the 4-to-16 one-hot decoder stage downstream.
- Steps through a masked set of 16 channels, lowest index first, holding each for a programmable dwell time.
- Runs either one pass (one-shot) or continuously with wrap-around.
- `sel` connects directly to the decoder select input; `sel_valid` gates the decoder output at the consumer.

Parameters:
- DWELL_W, 8, width of the dwell count; each channel is held for dwell+1 cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; ignored while busy=1.
- stop  in  1  one-cycle abort request.
- hold  in  1  level; freezes the dwell countdown while high.
- one_shot  in  1  mode, sampled at start: 1 = single pass, 0 = continuous.
- dwell  in  DWELL_W  dwell count, sampled at start.
- ch_mask  in  16  enabled channels, sampled at start; bit i enables channel i.
- sel  out  4  current channel index.
- sel_valid  out  1  sel is an active channel.
- step  out  1  one-cycle pulse in the first cycle of each dwell period.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan ends.

Behaviour:
- Reset (async): sel=0, sel_valid=0, step=0, busy=0, done=0, state=IDLE, dwell counter=0, latched mode/dwell/mask=0. Reset takes effect immediately and overrides any activity.
- States: IDLE and RUN.
- IDLE, start=1, stop=0, ch_mask!=0:
  - Latch one_shot, dwell and ch_mask.
  - Load sel = lowest set bit of ch_mask; counter = dwell.
  - Set sel_valid=1, busy=1, step=1 on the next cycle; go to RUN.
  - Latency is one cycle from start to valid output.
- IDLE, start=1, ch_mask==0: stay in IDLE; done=1 for one cycle next cycle; sel_valid stays 0.
- RUN, each edge:
  - If stop=1: go to IDLE; sel_valid=0, busy=0; done is not pulsed; sel holds its value.
  - Else if hold=1: counter and sel unchanged; step=0.
  - Else if counter!=0: decrement counter; step=0.
  - Else (counter==0): dwell has expired.
    - Compute next = next set bit of the latched mask above sel, wrapping to the lowest set bit. wrap=1 when next<=sel.
    - If one_shot=1 and wrap=1: go to IDLE; sel_valid=0, busy=0, done=1 for one cycle; sel holds the last channel.
    - Otherwise: sel=next, counter=dwell, step=1.
- One enabled channel, continuous mode: sel is unchanged, but step still pulses every dwell+1 cycles.
- start while busy=1 is ignored. start and stop in the same cycle: stop wins (no scan starts).
- Mask, dwell and mode changes during RUN take effect only at the next start.
- The counter never underflows; dwell=0 gives one cycle per channel.
- step, done and sel_valid are registered outputs; there are no combinational paths from inputs to outputs.

Decomposition:
- Package scan_pkg:
  - SEL_W=4, N_CH=16.
  - state enum {IDLE, RUN}.
- Sub-module scan_next_ch (combinational):
  - Inputs: mask[15:0], cur[3:0].
  - Outputs: next[3:0], wrap, first[3:0] (lowest set bit).
  - Implemented as a rotate plus priority search.

Test Plan:
- Reset: assert rst mid-run with dwell=5 -> sel=0 and sel_valid=busy=step=done=0 in the same cycle, without waiting for a clock edge; the block stays in IDLE after release.
- Full one-shot pass: mask=16'hFFFF, dwell=0, one_shot=1, pulse start -> sel=0..15 on consecutive cycles, step high for 16 cycles, then sel_valid=0 and done=1 for one cycle with sel=15.
- Sparse continuous scan: mask=16'h8421, dwell=2 -> sel sequence 0,0,0,5,5,5,10,10,10,15,15,15,0,... with step on the first cycle of each triple. stop -> sel_valid=0 next cycle, no done pulse.
- Empty mask: ch_mask=0, start -> done=1 for one cycle one cycle after start; busy and sel_valid stay 0.
- Hold: mask=16'h0003, dwell=1, hold high for 3 cycles during channel 0 -> channel 0 lasts 5 cycles, channel 1 lasts 2 cycles.
- Collisions: start+stop in the same cycle in IDLE -> stays IDLE. start during RUN -> ignored, scan sequence unchanged.
